// File: rtl/pattern_sender.sv
// ---------------------------------------------------------------------------
// pattern_sender
//
// Transmit-side symbol generator. Each frame is PAY_LEN programmable 2-bit
// payload symbols followed by the fixed trailer 1,2,3. Frames repeat a
// programmed number of times and are separated by GAP idle cycles.
//
// Parameters
//   PAY_LEN      payload symbols per frame (1..16)
//   GAP          idle cycles (valid=0) between frames, 0 = back-to-back (0..15)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   start        one-cycle request, honoured only while idle
//   payload      payload symbols, symbol i = payload[2i+1:2i], symbol 0 first
//   repeat_count number of frames to send (0 behaves as 1)
//   ready        sink accepts a symbol this cycle
//   num          current symbol
//   valid        num holds a symbol
//   busy         transfer sequence in progress
//   done         one-cycle pulse after the final trailer symbol is accepted
//   frame_cnt    frames completed since the last start (saturates at 15)
//
// All outputs are registered. The port carrying the frame count is called
// repeat_count because "repeat" is a reserved word in SystemVerilog.
// ---------------------------------------------------------------------------
module pattern_sender #(
    parameter int PAY_LEN = 8,
    parameter int GAP     = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*PAY_LEN-1:0]   payload,
    input  logic [3:0]             repeat_count,
    input  logic                   ready,
    output logic [1:0]             num,
    output logic                   valid,
    output logic                   busy,
    output logic                   done,
    output logic [3:0]             frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_PAYLOAD = 3'd1,
        S_T1      = 3'd2,
        S_T2      = 3'd3,
        S_T3      = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    localparam logic [3:0] LAST_IDX = 4'(PAY_LEN - 1);
    localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? (GAP - 1) : 0);
    localparam bit         HAS_GAP  = (GAP > 0);

    // Select payload symbol i from a packed payload word.
    function automatic logic [1:0] sym_at(input logic [2*PAY_LEN-1:0] p,
                                          input logic [3:0]           i);
        logic [2*PAY_LEN-1:0] sh;
        sh = p >> {i, 1'b0};
        return sh[1:0];
    endfunction

    state_t               state_r,     state_s;
    logic [2*PAY_LEN-1:0] payload_r,   payload_s;
    logic [3:0]           rep_r,       rep_s;
    logic [3:0]           idx_r,       idx_s;
    logic [3:0]           gap_cnt_r,   gap_cnt_s;
    logic [1:0]           num_r,       num_s;
    logic                 valid_r,     valid_s;
    logic                 busy_r,      busy_s;
    logic                 done_r,      done_s;
    logic [3:0]           frame_cnt_r, frame_cnt_s;

    logic                 accept_s;
    logic                 more_s;

    assign accept_s = valid_r & ready;
    // Another frame is due if the one finishing now is not the last.
    assign more_s   = ({1'b0, frame_cnt_r} + 5'd1) < {1'b0, rep_r};

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_s     = state_r;
        payload_s   = payload_r;
        rep_s       = rep_r;
        idx_s       = idx_r;
        gap_cnt_s   = gap_cnt_r;
        num_s       = num_r;
        valid_s     = valid_r;
        busy_s      = busy_r;
        done_s      = 1'b0;
        frame_cnt_s = frame_cnt_r;

        case (state_r)
            S_IDLE: begin
                if (start) begin
                    state_s     = S_PAYLOAD;
                    payload_s   = payload;
                    rep_s       = (repeat_count == 4'd0) ? 4'd1 : repeat_count;
                    frame_cnt_s = 4'd0;
                    idx_s       = 4'd0;
                    busy_s      = 1'b1;
                    valid_s     = 1'b1;
                    num_s       = payload[1:0];
                end else begin
                    busy_s  = 1'b0;
                    valid_s = 1'b0;
                    num_s   = 2'd0;
                end
            end

            S_PAYLOAD: begin
                if (accept_s) begin
                    if (idx_r == LAST_IDX) begin
                        state_s = S_T1;
                        idx_s   = 4'd0;
                        num_s   = 2'd1;
                    end else begin
                        idx_s = idx_r + 4'd1;
                        num_s = sym_at(payload_r, idx_r + 4'd1);
                    end
                end else begin
                    state_s = S_PAYLOAD;
                end
            end

            S_T1: begin
                if (accept_s) begin
                    state_s = S_T2;
                    num_s   = 2'd2;
                end else begin
                    state_s = S_T1;
                end
            end

            S_T2: begin
                if (accept_s) begin
                    state_s = S_T3;
                    num_s   = 2'd3;
                end else begin
                    state_s = S_T2;
                end
            end

            S_T3: begin
                if (accept_s) begin
                    frame_cnt_s = (frame_cnt_r == 4'hF) ? 4'hF : (frame_cnt_r + 4'd1);
                    if (more_s) begin
                        if (HAS_GAP) begin
                            state_s   = S_GAP;
                            gap_cnt_s = 4'd0;
                            valid_s   = 1'b0;
                            num_s     = 2'd0;
                        end else begin
                            state_s = S_PAYLOAD;
                            idx_s   = 4'd0;
                            valid_s = 1'b1;
                            num_s   = payload_r[1:0];
                        end
                    end else begin
                        state_s = S_DONE;
                        valid_s = 1'b0;
                        num_s   = 2'd0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end
                end else begin
                    state_s = S_T3;
                end
            end

            S_GAP: begin
                // gap_cnt_r counts the idle cycles already spent in this gap.
                if (gap_cnt_r == GAP_LAST) begin
                    state_s   = S_PAYLOAD;
                    gap_cnt_s = 4'd0;
                    idx_s     = 4'd0;
                    valid_s   = 1'b1;
                    num_s     = payload_r[1:0];
                end else begin
                    gap_cnt_s = gap_cnt_r + 4'd1;
                end
            end

            S_DONE: begin
                state_s = S_IDLE;
                valid_s = 1'b0;
                num_s   = 2'd0;
                busy_s  = 1'b0;
            end

            default: begin
                state_s = S_IDLE;
                valid_s = 1'b0;
                num_s   = 2'd0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            payload_r   <= '0;
            rep_r       <= 4'd0;
            idx_r       <= 4'd0;
            gap_cnt_r   <= 4'd0;
            num_r       <= 2'd0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            frame_cnt_r <= 4'd0;
        end else begin
            state_r     <= state_s;
            payload_r   <= payload_s;
            rep_r       <= rep_s;
            idx_r       <= idx_s;
            gap_cnt_r   <= gap_cnt_s;
            num_r       <= num_s;
            valid_r     <= valid_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            frame_cnt_r <= frame_cnt_s;
        end
    end

    assign num       = num_r;
    assign valid     = valid_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign frame_cnt = frame_cnt_r;

endmodule

// File: tb/tb_pattern_sender.sv
// ---------------------------------------------------------------------------
// tb_pattern_sender
//
// Self-checking bench for pattern_sender (PAY_LEN=4, GAP=2). The reference
// model is a queue of expected symbols built per run from the frame rules
// (payload symbols then 1,2,3, repeated), plus gap/done bookkeeping. Outputs
// are sampled on the falling edge; ready/start are driven there too.
// ---------------------------------------------------------------------------
module tb_pattern_sender;

    localparam int PAY_LEN = 4;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] payload;
    logic [3:0] repeat_count;
    logic       ready;
    logic [1:0] num;
    logic       valid;
    logic       busy;
    logic       done;
    logic [3:0] frame_cnt;

    int n_total = 0;
    int n_fail  = 0;

    pattern_sender #(.PAY_LEN(PAY_LEN), .GAP(GAP)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .payload      (payload),
        .repeat_count (repeat_count),
        .ready        (ready),
        .num          (num),
        .valid        (valid),
        .busy         (busy),
        .done         (done),
        .frame_cnt    (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always 1; mode 1: random ready; mode 2: 3-cycle stall at index 2
    task automatic run_seq(input logic [7:0] pl, input logic [3:0] rp, input int mode,
                           input bit abort_t2, input bit poke_start);
        int         q[$];
        int         rep_eff;
        int         sent;
        int         frames;
        int         gap_left;
        int         cycles;
        int         stall;
        int         exp_cycles;
        bit         finished;
        logic [7:0] tmp;

        rep_eff  = (rp == 4'd0) ? 1 : int'(rp);
        sent     = 0;
        frames   = 0;
        gap_left = 0;
        cycles   = 0;
        stall    = 0;
        finished = 1'b0;
        for (int f = 0; f < rep_eff; f++) begin
            for (int i = 0; i < PAY_LEN; i++) begin
                tmp = pl >> (2 * i);
                q.push_back(int'(tmp[1:0]));
            end
            q.push_back(1);
            q.push_back(2);
            q.push_back(3);
        end
        exp_cycles = rep_eff * (PAY_LEN + 3) + (rep_eff - 1) * GAP + ((mode == 2) ? 3 : 0);

        @(negedge clk);
        start        = 1'b1;
        payload      = pl;
        repeat_count = rp;
        @(negedge clk);

        for (int c = 0; c < 400; c++) begin
            start        = 1'b0;
            payload      = 8'($urandom);
            repeat_count = 4'($urandom);
            if (gap_left > 0) begin
                chk("gap_valid", 8'(valid), 8'd0);
                chk("gap_num",   8'(num),   8'd0);
                chk("gap_busy",  8'(busy),  8'd1);
                gap_left--;
                ready = 1'($urandom);
            end else if (q.size() > 0) begin
                chk("valid",     8'(valid),     8'd1);
                chk("num",       8'(num),       8'(q[0]));
                chk("busy",      8'(busy),      8'd1);
                chk("done_low",  8'(done),      8'd0);
                chk("frame_cnt", 8'(frame_cnt), 8'(frames));
                if (abort_t2 && frames == 1 && sent == PAY_LEN + 1) begin
                    reset = 1'b1;
                    ready = 1'b1;
                    @(negedge clk);
                    reset = 1'b0;
                    chk("rst_valid", 8'(valid),     8'd0);
                    chk("rst_num",   8'(num),       8'd0);
                    chk("rst_busy",  8'(busy),      8'd0);
                    chk("rst_fcnt",  8'(frame_cnt), 8'd0);
                    chk("rst_done",  8'(done),      8'd0);
                    finished = 1'b1;
                    break;
                end
                case (mode)
                    1: ready = ($urandom_range(0, 99) < 60);
                    2: begin
                        if (sent == 2 && stall < 3) begin
                            ready = 1'b0;
                            stall++;
                        end else begin
                            ready = 1'b1;
                        end
                    end
                    default: ready = 1'b1;
                endcase
                if (ready) begin
                    void'(q.pop_front());
                    sent++;
                    if (sent == PAY_LEN + 3) begin
                        sent = 0;
                        frames++;
                        if (q.size() > 0) gap_left = GAP;
                    end
                end
                if (poke_start && $urandom_range(0, 3) == 0) start = 1'b1;
            end else begin
                chk("done_pulse", 8'(done),      8'd1);
                chk("done_busy",  8'(busy),      8'd0);
                chk("done_valid", 8'(valid),     8'd0);
                chk("done_fcnt",  8'(frame_cnt), 8'(frames));
                if (mode != 1) chk("latency", 8'(cycles), 8'(exp_cycles));
                if (poke_start) start = 1'b1;
                @(negedge clk);
                start = 1'b0;
                chk("idle_done",  8'(done),  8'd0);
                chk("idle_busy",  8'(busy),  8'd0);
                chk("idle_valid", 8'(valid), 8'd0);
                finished = 1'b1;
                break;
            end
            cycles++;
            @(negedge clk);
        end
        if (!finished) chk("timeout", 8'd0, 8'd1);
    endtask

    initial begin
        reset        = 1'b1;
        start        = 1'b0;
        ready        = 1'b1;
        payload      = 8'd0;
        repeat_count = 4'd0;
        repeat (3) @(negedge clk);
        chk("reset_num",   8'(num),       8'd0);
        chk("reset_valid", 8'(valid),     8'd0);
        chk("reset_busy",  8'(busy),      8'd0);
        chk("reset_done",  8'(done),      8'd0);
        chk("reset_fcnt",  8'(frame_cnt), 8'd0);
        reset = 1'b0;

        run_seq(8'b00_11_10_01, 4'd1, 0, 1'b0, 1'b0);
        run_seq(8'b00_11_10_01, 4'd2, 0, 1'b0, 1'b0);
        run_seq(8'b00_11_10_01, 4'd0, 0, 1'b0, 1'b0);
        run_seq(8'b00_11_10_01, 4'd1, 2, 1'b0, 1'b0);
        run_seq(8'b00_11_10_01, 4'd3, 0, 1'b0, 1'b1);
        run_seq(8'b00_11_10_01, 4'd2, 0, 1'b1, 1'b0);
        run_seq(8'b00_11_10_01, 4'd1, 0, 1'b0, 1'b0);
        run_seq(8'b00_00_00_00, 4'd2, 0, 1'b0, 1'b0);
        run_seq(8'b11_10_01_11, 4'd15, 0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            run_seq(8'($urandom), 4'($urandom_range(0, 15)), 1, 1'b0, 1'b1);
        end

        $display("%0d/%0d checks passed", n_total - n_fail, n_total);
        $finish;
    end

endmodule

// File: doc/pattern_sender.md
Name: pattern_sender

Overview:
- Transmit-side counterpart of the symbol-sequence detector: generates the 2-bit symbol stream that the detector consumes.
- Each frame is a programmable payload of PAY_LEN symbols followed by the fixed trailer 1,2,3, which arms the detector.
- Frames repeat a programmed number of times, separated by idle gaps.
- Sits between a control/test master (start, payload, repeat) and a detector-style sink (num/valid/ready).

Parameters:
- PAY_LEN, 8, payload symbols per frame; legal range 1..16.
- GAP, 2, idle cycles with valid=0 between consecutive frames; 0 means back-to-back frames; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; honoured only in IDLE.
- payload  input  2*PAY_LEN  payload symbols; symbol i = payload[2i+1:2i]; symbol 0 is sent first.
- repeat  input  4  number of frames to send; 0 is treated as 1.
- ready  input  1  sink can accept a symbol this cycle.
- num  output  2  current symbol.
- valid  output  1  num holds a symbol.
- busy  output  1  a transfer sequence is in progress.
- done  output  1  one-cycle pulse after the final symbol of the final frame is accepted.
- frame_cnt  output  4  frames fully completed since the last start.

Behaviour:
- All outputs are registered. After reset: num=0, valid=0, busy=0, done=0, frame_cnt=0, state=IDLE.
- Reset overrides everything, including mid-frame. The next edge returns the block to IDLE and discards any in-flight symbol.
- States and transitions:
  - IDLE → PAYLOAD when start=1 is sampled.
  - PAYLOAD → T1 → T2 → T3, each advancing on an accepted symbol.
  - From T3 on accept: go to GAP if more frames remain and GAP>0; go to PAYLOAD if more frames remain and GAP=0; otherwise go to DONE.
  - GAP → PAYLOAD after exactly GAP cycles.
  - DONE → IDLE unconditionally after one cycle.
- Start handling:
  - At the edge where start=1 is sampled in IDLE, latch payload and repeat (0 becomes 1), clear frame_cnt and the symbol index, and set busy=1.
  - In the following cycle valid=1 and num=payload[1:0].
  - start is ignored in every state other than IDLE, including DONE.
  - Latched values are not affected by later changes on the payload or repeat inputs.
- Transfer handshake:
  - A symbol transfers on a cycle where valid=1 and ready=1.
  - While valid=1 and ready=0, num and valid hold stable.
  - valid never drops without a transfer, except on reset.
  - With ready held at 1, the block sends one symbol per cycle.
- Symbols sent in each state:
  - PAYLOAD: symbols 0..PAY_LEN-1 in index order. The index counts 0..PAY_LEN-1 and wraps to 0 on frame end.
  - T1, T2, T3: num = 1, 2, 3 respectively.
- Gap: valid=0 and num=0 for exactly GAP cycles. ready is don't-care.
- Frame completion: frame_cnt increments on the cycle the T3 symbol is accepted. It saturates at 15 and is not required to wrap.
- Completion signalling:
  - DONE lasts one cycle: done=1, busy=0, valid=0.
  - busy=1 from the cycle after start is sampled through the cycle the final T3 symbol is accepted.
- Payload symbol values are unrestricted. The payload may itself contain 1,2,3; the block does not filter it.
- Latency per frame with ready=1: PAY_LEN+3 cycles, plus GAP cycles between frames.
- Total latency with ready=1: repeat_eff*(PAY_LEN+3) + (repeat_eff-1)*GAP cycles from first valid to last accept.

Test Plan:
- PAY_LEN=4, GAP=2, payload=8'b00_11_10_01, repeat=1, ready=1 → num sequence 1,2,3,0,1,2,3 on 7 consecutive cycles; done pulses on the 8th cycle; frame_cnt=1; busy low afterward.
- Same setup with repeat=2 → the two frames are separated by exactly 2 cycles of valid=0; done pulses once; frame_cnt=2.
- repeat=0 → behaves exactly as repeat=1.
- ready=0 for 3 cycles while the payload index is 2 → num=3 and valid=1 hold for the full stall; the sequence then resumes unchanged; total length is 3 cycles longer.
- start pulsed while busy, and again in the DONE cycle → both ignored. Change payload mid-frame → the output stream is unchanged.
- reset asserted while in T2 → on the next cycle valid=0, num=0, busy=0, frame_cnt=0. A subsequent start produces a complete fresh frame.
- Loopback into the detector (payload all 0, GAP=0) → the detector output rises the cycle after the first T3 accept.
